// File: rtl/uart_rx_sampler.sv
// 16x oversampling UART receive front end: line synchroniser, start-edge detect,
// bit-period tick counter, bit voting and byte assembly. Optional macro
// UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting instead of a single mid-bit sample.
module uart_rx_sampler #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_i,
    input  logic       AcqSig_i,
    input  logic       p_ParityEnable_i,
    input  logic       p_ParityMethod_i,
    input  logic [4:0] State_i,
    input  logic [3:0] BitCounter_i,
    output logic       Rx_Synch_o,
    output logic       Bit_Synch_o,
    output logic [7:0] Byte_o,
    output logic       ByteValid_o,
    output logic       ParityErr_o,
    output logic       FrameErr_o
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ST_W   = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);

    localparam logic [ST_W-1:0] ST_INTERVAL  = 5'b00001;
    localparam logic [ST_W-1:0] ST_STARTBIT  = 5'b00010;
    localparam logic [ST_W-1:0] ST_DATABITS  = 5'b00100;
    localparam logic [ST_W-1:0] ST_PARITYBIT = 5'b01000;
    localparam logic [ST_W-1:0] ST_STOPBIT   = 5'b10000;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              rx_d_q, rx_d_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s8_q, s8_d;
    logic              start_err_q, start_err_d;
    logic              par_err_q, par_err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rx_synch_q, rx_synch_d;
    logic              bit_synch_q, bit_synch_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;

    logic in_interval;
    logic tick_active;
    logic bit_val;

    assign in_interval = (State_i == ST_INTERVAL);
    assign tick_active = AcqSig_i && !in_interval;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(OVERSAMPLE / 2 + 1);

    logic s7_q, s7_d;
    logic s9_q, s9_d;

    // Flanking samples around mid-bit, only kept when voting.
    always_comb begin
        s7_d = s7_q;
        s9_d = s9_q;
        if (tick_active) begin
            if (cnt_q == CNT_EARLY) s7_d = sync2_q;
            if (cnt_q == CNT_LATE)  s9_d = sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s7_q <= 1'b0;
            s9_q <= 1'b0;
        end else begin
            s7_q <= s7_d;
            s9_q <= s9_d;
        end
    end

    assign bit_val = (s7_q & s8_q) | (s7_q & s9_q) | (s8_q & s9_q);
`else
    assign bit_val = s8_q;
`endif

    // Synchroniser, edge detect, tick counter and per-bit actions.
    always_comb begin
        sync1_d      = Rx_i;
        sync2_d      = sync1_q;
        rx_d_d       = rx_d_q;
        cnt_d        = cnt_q;
        s8_d         = s8_q;
        start_err_d  = start_err_q;
        par_err_d    = par_err_q;
        data_d       = data_q;
        rx_synch_d   = 1'b0;
        bit_synch_d  = 1'b0;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (AcqSig_i) begin
            rx_d_d = sync2_q;
        end

        if (in_interval) begin
            // Counter parks at zero; a start edge also lands here as sample 0.
            cnt_d = '0;
            if (AcqSig_i && !sync2_q && rx_d_q) begin
                rx_synch_d  = 1'b1;
                start_err_d = 1'b0;
                par_err_d   = 1'b0;
                data_d      = '0;
            end
        end else if (AcqSig_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_MID) begin
                s8_d = sync2_q;
            end
            if (cnt_q == CNT_LAST) begin
                bit_synch_d = 1'b1;
                case (State_i)
                    ST_STARTBIT: begin
                        start_err_d = bit_val;
                    end
                    ST_DATABITS: begin
                        if (BitCounter_i < 4'(DATA_W)) begin
                            data_d[BitCounter_i[2:0]] = bit_val;
                        end
                    end
                    ST_PARITYBIT: begin
                        par_err_d = ((^data_q) ^ bit_val) != p_ParityMethod_i;
                    end
                    ST_STOPBIT: begin
                        byte_d       = data_q;
                        frame_err_d  = start_err_q | ~bit_val;
                        parity_err_d = par_err_q & p_ParityEnable_i;
                        byte_valid_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Line-side flops reset high so a released reset on an idle line sees no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_d_q       <= 1'b1;
            cnt_q        <= '0;
            s8_q         <= 1'b0;
            start_err_q  <= 1'b0;
            par_err_q    <= 1'b0;
            data_q       <= '0;
            rx_synch_q   <= 1'b0;
            bit_synch_q  <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            rx_d_q       <= rx_d_d;
            cnt_q        <= cnt_d;
            s8_q         <= s8_d;
            start_err_q  <= start_err_d;
            par_err_q    <= par_err_d;
            data_q       <= data_d;
            rx_synch_q   <= rx_synch_d;
            bit_synch_q  <= bit_synch_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign Rx_Synch_o  = rx_synch_q;
    assign Bit_Synch_o = bit_synch_q;
    assign Byte_o      = byte_q;
    assign ByteValid_o = byte_valid_q;
    assign ParityErr_o = parity_err_q;
    assign FrameErr_o  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler with a small Rx FSM model driving State_i/BitCounter_i.
module tb_uart_rx_sampler;

    localparam logic [4:0] ST_INTERVAL  = 5'b00001;
    localparam logic [4:0] ST_STARTBIT  = 5'b00010;
    localparam logic [4:0] ST_DATABITS  = 5'b00100;
    localparam logic [4:0] ST_PARITYBIT = 5'b01000;
    localparam logic [4:0] ST_STOPBIT   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rx_i = 1'b1;
    logic       AcqSig_i = 1'b0;
    logic       p_ParityEnable_i = 1'b0;
    logic       p_ParityMethod_i = 1'b0;
    logic [4:0] State_i;
    logic [3:0] BitCounter_i;
    logic       Rx_Synch_o;
    logic       Bit_Synch_o;
    logic [7:0] Byte_o;
    logic       ByteValid_o;
    logic       ParityErr_o;
    logic       FrameErr_o;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rs_count = 0;
    int rs_time = 0;
    int bs_count = 0;
    int bs_times[$];
    int bv_count = 0;
    logic bv_with_bs = 1'b0;

    uart_rx_sampler dut (
        .clk              (clk),
        .rst              (rst),
        .Rx_i             (Rx_i),
        .AcqSig_i         (AcqSig_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .p_ParityMethod_i (p_ParityMethod_i),
        .State_i          (State_i),
        .BitCounter_i     (BitCounter_i),
        .Rx_Synch_o       (Rx_Synch_o),
        .Bit_Synch_o      (Bit_Synch_o),
        .Byte_o           (Byte_o),
        .ByteValid_o      (ByteValid_o),
        .ParityErr_o      (ParityErr_o),
        .FrameErr_o       (FrameErr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the Rx state machine that consumes the sampler pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            State_i      <= ST_INTERVAL;
            BitCounter_i <= 4'd0;
        end else if (Rx_Synch_o && State_i == ST_INTERVAL) begin
            State_i <= ST_STARTBIT;
        end else if (Bit_Synch_o) begin
            case (State_i)
                ST_STARTBIT: begin
                    State_i      <= ST_DATABITS;
                    BitCounter_i <= 4'd0;
                end
                ST_DATABITS: begin
                    if (BitCounter_i == 4'd7)
                        State_i <= p_ParityEnable_i ? ST_PARITYBIT : ST_STOPBIT;
                    else
                        BitCounter_i <= 4'(BitCounter_i + 4'd1);
                end
                ST_PARITYBIT: State_i <= ST_STOPBIT;
                default:      State_i <= ST_INTERVAL;
            endcase
        end
    end

    always @(negedge clk) begin
        if (Rx_Synch_o) begin
            rs_count = rs_count + 1;
            rs_time  = cyc;
        end
        if (Bit_Synch_o) begin
            bs_count = bs_count + 1;
            bs_times.push_back(cyc);
        end
        if (ByteValid_o) begin
            bv_count   = bv_count + 1;
            bv_with_bs = Bit_Synch_o;
        end
    end

    // One acquisition tick every 4 clk; line value set 2 clk ahead of the tick.
    task automatic tick(input logic line);
        @(negedge clk) Rx_i = line;
        @(negedge clk);
        @(negedge clk) AcqSig_i = 1'b1;
        @(negedge clk) AcqSig_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_odd,
                              input logic par_bit, input logic stop_bit,
                              input int glitch_k, input int stop_low_k);
        logic [10:0] frame;
        logic [3:0]  bi;
        logic        line;
        int          nbits;
        p_ParityEnable_i = par_en;
        p_ParityMethod_i = par_odd;
        frame      = '1;
        frame[0]   = 1'b0;
        frame[8:1] = data;
        if (par_en) begin
            frame[9]  = par_bit;
            frame[10] = stop_bit;
            nbits     = 11;
        end else begin
            frame[9]  = stop_bit;
            nbits     = 10;
        end
        for (int i = 0; i < 4; i++) tick(1'b1);
        tick(1'b0);
        for (int k = 1; k <= 16 * nbits; k++) begin
            bi   = 4'((k - 1) / 16);
            line = frame[bi];
            if (k == glitch_k) line = 1'b0;
            if (k == stop_low_k || k == stop_low_k + 1) line = 1'b0;
            tick(line);
        end
        for (int i = 0; i < 3; i++) tick(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (Rx_Synch_o !== 1'b0) begin errors++; $display("FAIL reset_rx_synch got %b want 0", Rx_Synch_o); end
        checks++; if (Bit_Synch_o !== 1'b0) begin errors++; $display("FAIL reset_bit_synch got %b want 0", Bit_Synch_o); end
        checks++; if (Byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", Byte_o); end
        checks++; if (ByteValid_o !== 1'b0) begin errors++; $display("FAIL reset_byte_valid got %b want 0", ByteValid_o); end
        checks++; if (ParityErr_o !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", ParityErr_o); end
        checks++; if (FrameErr_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", FrameErr_o); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_byte_no_parity();
        int rs0, bs0, bv0, n;
        rs0 = rs_count; bs0 = bs_count; bv0 = bv_count;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        n = bs_count - bs0;
        checks++; if (rs_count - rs0 !== 1) begin errors++; $display("FAIL a5_rx_synch_pulses got %0d want 1", rs_count - rs0); end
        checks++; if (n !== 10) begin errors++; $display("FAIL a5_bit_synch_pulses got %0d want 10", n); end
        if (n > 0) begin
            checks++;
            if (bs_times[bs0] - rs_time !== 64) begin
                errors++; $display("FAIL a5_first_bit_period got %0d want 64", bs_times[bs0] - rs_time);
            end
        end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (bs_times[bs0 + i] - bs_times[bs0 + i - 1] !== 64) begin
                errors++; $display("FAIL a5_bit_spacing_%0d got %0d want 64", i, bs_times[bs0 + i] - bs_times[bs0 + i - 1]);
            end
        end
        checks++; if (bv_count - bv0 !== 1) begin errors++; $display("FAIL a5_byte_valid_pulses got %0d want 1", bv_count - bv0); end
        checks++; if (bv_with_bs !== 1'b1) begin errors++; $display("FAIL a5_valid_with_bit_synch got %b want 1", bv_with_bs); end
        checks++; if (Byte_o !== 8'hA5) begin errors++; $display("FAIL a5_byte got %h want a5", Byte_o); end
        checks++; if (ParityErr_o !== 1'b0) begin errors++; $display("FAIL a5_parity_err got %b want 0", ParityErr_o); end
        checks++; if (FrameErr_o !== 1'b0) begin errors++; $display("FAIL a5_frame_err got %b want 0", FrameErr_o); end
    endtask

    task automatic test_parity();
        int bs0;
        bs0 = bs_count;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        checks++; if (bs_count - bs0 !== 11) begin errors++; $display("FAIL par_bit_synch_pulses got %0d want 11", bs_count - bs0); end
        checks++; if (Byte_o !== 8'h3C) begin errors++; $display("FAIL par_even0_byte got %h want 3c", Byte_o); end
        checks++; if (ParityErr_o !== 1'b0) begin errors++; $display("FAIL par_even0_err got %b want 0", ParityErr_o); end
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        checks++; if (ParityErr_o !== 1'b1) begin errors++; $display("FAIL par_even1_err got %b want 1", ParityErr_o); end
        checks++; if (FrameErr_o !== 1'b0) begin errors++; $display("FAIL par_even1_frame_err got %b want 0", FrameErr_o); end
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        checks++; if (ParityErr_o !== 1'b0) begin errors++; $display("FAIL par_odd1_err got %b want 0", ParityErr_o); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        checks++; if (FrameErr_o !== 1'b1) begin errors++; $display("FAIL ferr_set got %b want 1", FrameErr_o); end
        checks++; if (Byte_o !== 8'h00) begin errors++; $display("FAIL ferr_byte got %h want 00", Byte_o); end
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        checks++; if (FrameErr_o !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", FrameErr_o); end
        checks++; if (Byte_o !== 8'hFF) begin errors++; $display("FAIL ferr_next_byte got %h want ff", Byte_o); end
    endtask

    task automatic test_glitch();
        logic [7:0] exp_byte;
`ifdef UART_RX_MAJORITY_VOTE_EN
        exp_byte = 8'hFF;
`else
        exp_byte = 8'hF7;
`endif
        // Data bit 3 is frame bit 4; its count-8 sample lands on tick 16*4+9.
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 73, -1);
        checks++; if (Byte_o !== exp_byte) begin errors++; $display("FAIL glitch_byte got %h want %h", Byte_o, exp_byte); end
    endtask

    task automatic test_reset_mid_byte();
        int bv0, rs0;
        p_ParityEnable_i = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1);
        tick(1'b0);
        for (int k = 1; k <= 60; k++) tick((k <= 16) ? 1'b0 : 1'b1);
        checks++; if (State_i !== ST_DATABITS) begin errors++; $display("FAIL rst_mid_in_databits got %b want %b", State_i, ST_DATABITS); end
        bv0 = bv_count;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checks++; if (Rx_Synch_o !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_synch got %b want 0", Rx_Synch_o); end
        checks++; if (Bit_Synch_o !== 1'b0) begin errors++; $display("FAIL rst_mid_bit_synch got %b want 0", Bit_Synch_o); end
        checks++; if (Byte_o !== 8'h00) begin errors++; $display("FAIL rst_mid_byte got %h want 00", Byte_o); end
        checks++; if (ByteValid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_byte_valid got %b want 0", ByteValid_o); end
        checks++; if (ParityErr_o !== 1'b0) begin errors++; $display("FAIL rst_mid_parity_err got %b want 0", ParityErr_o); end
        checks++; if (FrameErr_o !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_err got %b want 0", FrameErr_o); end
        rs0 = rs_count;
        for (int i = 0; i < 120; i++) tick(1'b1);
        checks++; if (bv_count !== bv0) begin errors++; $display("FAIL rst_mid_no_valid got %0d want %0d", bv_count, bv0); end
        checks++; if (rs_count !== rs0) begin errors++; $display("FAIL rst_mid_no_edge got %0d want %0d", rs_count, rs0); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        checks++; if (Byte_o !== 8'h5A) begin errors++; $display("FAIL rst_mid_next_byte got %h want 5a", Byte_o); end
        checks++; if (bv_count - bv0 !== 1) begin errors++; $display("FAIL rst_mid_next_valid got %0d want 1", bv_count - bv0); end
    endtask

    task automatic test_edge_outside_interval();
        int rs0, bv0;
        rs0 = rs_count; bv0 = bv_count;
        // Two-tick low pulse early in the stop bit, away from the sample ticks.
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 16 * 9 + 3);
        checks++; if (rs_count - rs0 !== 1) begin errors++; $display("FAIL stop_edge_rx_synch got %0d want 1", rs_count - rs0); end
        checks++; if (bv_count - bv0 !== 1) begin errors++; $display("FAIL stop_edge_valid got %0d want 1", bv_count - bv0); end
        checks++; if (Byte_o !== 8'h81) begin errors++; $display("FAIL stop_edge_byte got %h want 81", Byte_o); end
        checks++; if (FrameErr_o !== 1'b0) begin errors++; $display("FAIL stop_edge_frame_err got %b want 0", FrameErr_o); end
    endtask

    initial begin
        test_reset();
        test_byte_no_parity();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_mid_byte();
        test_edge_outside_interval();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front end of the UART receive core: synchronises the raw Rx line, detects start edges, counts 16x acquisition ticks per bit, votes the bit value and assembles the received byte. It produces `Rx_Synch_o` and `Bit_Synch_o` for the Rx state machine and consumes that machine's one-hot state and data-bit index. It delivers the byte with parity and framing status to the Rx buffer.

## Interface
- `OVERSAMPLE`, 16: acquisition ticks per bit. The counter is 4 bits; only 16 is supported.
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `Rx_i`  input  1  raw asynchronous serial line; idle is high.
- `AcqSig_i`  input  1  one-clk tick at 16x baud. Consecutive ticks are at least 3 clk apart.
- `p_ParityEnable_i`  input  1  1 = a parity bit is present.
- `p_ParityMethod_i`  input  1  0 = even parity, 1 = odd parity.
- `State_i`  input  5  Rx FSM state, one-hot: INTERVAL 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000.
- `BitCounter_i`  input  4  data-bit index, 0..7, valid in DATABITS.
- `Rx_Synch_o`  output  1  one-clk pulse: start edge detected.
- `Bit_Synch_o`  output  1  one-clk pulse: current bit period ended.
- `Byte_o`  output  8  last received byte, LSB first on the line.
- `ByteValid_o`  output  1  one-clk pulse: `Byte_o` and the error flags have been updated.
- `ParityErr_o`  output  1  parity mismatch for the last byte. Holds until the next `ByteValid_o`.
- `FrameErr_o`  output  1  start bit sampled 1 or stop bit sampled 0. Holds until the next `ByteValid_o`.

## Operation
- **Synchroniser:** two flops on `Rx_i` give `rx_s`. Both flops reset to 1. An edge register `rx_d` is updated on every `AcqSig_i` tick.
- **Edge detection:** active only while `State_i` = INTERVAL. A tick with `rx_s`=0 and `rx_d`=1 causes the following:
  - `Rx_Synch_o` = 1 on the next clk.
  - The tick counter is loaded to 0; this tick is sample 0.
  - `start_err`, `par_err` and the data shift register are cleared.
- **Tick counter (4 bits):** outside INTERVAL, every tick increments the counter. A tick arriving at count 15 wraps the counter to 0 and pulses `Bit_Synch_o` on the next clk. In INTERVAL the counter holds at 0, except when loaded by edge detection.
- **Bit sampling:** samples are captured on ticks arriving at counts 7, 8 and 9. The bit value is the majority of the three; see Configuration.
- **Actions on each `Bit_Synch_o`, by `State_i`:**
  - STARTBIT: `start_err` = bit value.
  - DATABITS: `data[BitCounter_i]` = bit value.
  - PARITYBIT: `par_err` = (^data ^ bit) != `p_ParityMethod_i`.
  - STOPBIT: `Byte_o` = data; `FrameErr_o` = `start_err` | ~bit; `ParityErr_o` = `par_err` & `p_ParityEnable_i`; `ByteValid_o` pulses.
- An edge occurring while `State_i` is not INTERVAL is ignored.
- **Reset (including mid-byte):**
  - `Rx_Synch_o`, `Bit_Synch_o`, `ByteValid_o`, `ParityErr_o`, `FrameErr_o` = 0.
  - `Byte_o` = 8'h00; counter = 0.
  - Synchroniser flops and `rx_d` = 1, so no start edge is detected on release while the line is high.

## Timing
- Line-to-`rx_s` latency: 2 clk. Edge detection happens on the first tick after that.
- `Rx_Synch_o` and `Bit_Synch_o` are registered and assert 1 clk after the qualifying tick.
- The FSM sees its next state 1 clk after each pulse. This is always before the next tick, given the 3-clk tick spacing.
- Bit period: exactly 16 ticks, measured from edge detection. A frame with parity has 11 `Bit_Synch_o` pulses; without parity it has 10.
- `ByteValid_o` asserts in the same clk as the STOPBIT `Bit_Synch_o`. `Byte_o` and the error flags are stable from that clk onward.
- When `AcqSig_i` and `rst` are high in the same clk, reset wins.

## Configuration
- Macro: `UART_RX_MAJORITY_VOTE_EN`.
- **Defined:** the bit value is the 2-of-3 majority of the samples at counts 7, 8 and 9.
- **Undefined:** the bit value is the single sample at count 8; the samples at counts 7 and 9 are not stored. All timing is identical in both builds.

## Test plan
- **0xA5, parity disabled, ticks every 4 clk:**
  - 1 `Rx_Synch_o` pulse, then 10 `Bit_Synch_o` pulses spaced 64 clk apart.
  - `Byte_o` = 8'hA5 with `ByteValid_o` pulsing once.
  - `ParityErr_o` = 0, `FrameErr_o` = 0.
- **0x3C, even parity:**
  - Parity bit 0 → `ParityErr_o` = 0.
  - Repeat with parity bit 1 → `ParityErr_o` = 1.
  - Odd parity with parity bit 1 → `ParityErr_o` = 0.
- **0x00 with stop bit driven 0:** `FrameErr_o` = 1 and `Byte_o` = 8'h00. A following good frame 0xFF clears `FrameErr_o` to 0.
- **Glitch rejection, byte 0xFF:** drive bit 3 low only during tick count 8.
  - With the macro defined: `Byte_o` = 8'hFF.
  - With the macro undefined: `Byte_o` = 8'hF7.
- **Reset mid-byte:**
  - Assert `rst` for 1 clk during DATABITS: all outputs read 0 on the next clk and no `ByteValid_o` pulses.
  - A following frame 0x5A is received correctly.
- **Edge outside INTERVAL:** a low pulse on `Rx_i` during STOPBIT sampling, with `State_i` = STOPBIT, produces no `Rx_Synch_o` pulse.
